// File: rtl/pedal_chain_sequencer_if.sv
// Bus bundle for pedal_chain_sequencer: sample in/out strobes, per-slot effect
// handshake and status flags. The sequencer uses the slave side.
interface pedal_chain_sequencer_if #(
  parameter int WIDTH     = 16,
  parameter int NUM_SLOTS = 4
);
  logic                         sample_valid_in;
  logic [WIDTH-1:0]             Signal_in;
  logic [NUM_SLOTS-1:0]         enable;
  logic [WIDTH-1:0]             fx_send;
  logic [NUM_SLOTS-1:0]         fx_start;
  logic [NUM_SLOTS-1:0]         fx_done;
  logic [NUM_SLOTS*WIDTH-1:0]   fx_return;
  logic [WIDTH-1:0]             Signal_out;
  logic                         sample_valid_out;
  logic                         busy;
  logic                         overrun;
  logic [NUM_SLOTS-1:0]         fault;

  modport master (
    output sample_valid_in, Signal_in, enable, fx_done, fx_return,
    input  fx_send, fx_start, Signal_out, sample_valid_out, busy, overrun, fault
  );

  modport slave (
    input  sample_valid_in, Signal_in, enable, fx_done, fx_return,
    output fx_send, fx_start, Signal_out, sample_valid_out, busy, overrun, fault
  );
endinterface

// File: rtl/pedal_chain_sequencer.sv
// Serial effect-chain sequencer: walks each sample through NUM_SLOTS effect
// slots with a start/done handshake and a per-slot linear bypass crossfade.
module pedal_chain_sequencer #(
  parameter int WIDTH     = 16,
  parameter int NUM_SLOTS = 4,
  parameter int RAMP_LOG2 = 6,
  parameter int TIMEOUT   = 1023
) (
  input  logic                   Clk,
  input  logic                   RESET,
  pedal_chain_sequencer_if.slave bus
);

  localparam int KW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int GW = RAMP_LOG2 + 1;
  localparam int PW = WIDTH + RAMP_LOG2 + 2;

  localparam logic [GW-1:0] G_MAX    = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [KW-1:0] K_LAST   = KW'(NUM_SLOTS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_MIX, S_OUT
  } state_t;

  state_t state, state_next;

  logic signed [WIDTH-1:0] acc, wet, out_q, send_q;
  logic [KW-1:0]           k;
  logic [GW-1:0]           g [NUM_SLOTS];
  logic [CW-1:0]           cnt;
  logic [NUM_SLOTS-1:0]    start_q, fault_q;
  logic                    valid_out_q, overrun_q;

  logic [GW-1:0]           g_cur, g_step;
  logic                    en_cur, skip, last, done_cur, expired;
  logic signed [WIDTH-1:0] ret_cur, acc_mix;
  logic signed [PW-1:0]    diff_ext, gain_ext, prod;

  // Slot-local decode and crossfade arithmetic for the current slot k.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    g_cur    = g[k];
    en_cur   = bus.enable[k];
    done_cur = bus.fx_done[k];
    ret_cur  = bus.fx_return[k*WIDTH +: WIDTH];
    skip     = (g_cur == '0) && !en_cur;
    last     = (k == K_LAST);
    expired  = (cnt == CNT_LAST);

    // (wet-acc)*g fits PW bits; the arithmetic shift floors toward -inf.
    diff_ext = PW'(wet) - PW'(acc);
    gain_ext = PW'(g_cur);
    prod     = diff_ext * gain_ext;
    acc_mix  = WIDTH'(PW'(acc) + (prod >>> RAMP_LOG2));

    g_step = g_cur;
    if (en_cur && (g_cur != G_MAX))
      g_step = g_cur + 1'b1;
    else if (!en_cur && (g_cur != '0))
      g_step = g_cur - 1'b1;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (bus.sample_valid_in) state_next = S_CHECK;
      S_CHECK: begin
        if (!skip)     state_next = S_ISSUE;
        else if (last) state_next = S_OUT;
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (done_cur || expired) state_next = S_MIX;
      S_MIX:   state_next = last ? S_OUT : S_CHECK;
      S_OUT:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      acc         <= '0;
      wet         <= '0;
      k           <= '0;
      cnt         <= '0;
      out_q       <= '0;
      send_q      <= '0;
      start_q     <= '0;
      valid_out_q <= 1'b0;
      overrun_q   <= 1'b0;
      fault_q     <= '0;
      // NOTE: the gain array is a small register file, reset explicitly so every slot starts fully dry.
      for (int i = 0; i < NUM_SLOTS; i++) g[i] <= '0;
    end else begin
      start_q     <= '0;
      valid_out_q <= 1'b0;
      if (bus.sample_valid_in && (state != S_IDLE)) overrun_q <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (bus.sample_valid_in) begin
            acc <= bus.Signal_in;
            k   <= '0;
          end
        end
        S_CHECK: begin
          if (skip) begin
            if (!last) k <= k + 1'b1;
          end else begin
            // Registered so the start pulse and fx_send both appear in ISSUE.
            start_q <= NUM_SLOTS'(1) << k;
            send_q  <= acc;
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          if (done_cur) begin
            wet <= ret_cur;
          end else if (expired) begin
            wet        <= acc;
            fault_q[k] <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_MIX: begin
          acc  <= acc_mix;
          g[k] <= g_step;
          if (!last) k <= k + 1'b1;
        end
        S_OUT: begin
          out_q       <= acc;
          valid_out_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.fx_send          = send_q;
  assign bus.fx_start         = start_q;
  assign bus.Signal_out       = out_q;
  assign bus.sample_valid_out = valid_out_q;
  assign bus.busy             = (state != S_IDLE);
  assign bus.overrun          = overrun_q;
  assign bus.fault            = fault_q;

endmodule
